// File: rtl/si_alien_tick_pkg.sv
// Shared pattern/level codes, pattern FSM state encoding and default timing
// constants for the alien-formation tick scheduler.
package si_alien_tick_pkg;

    localparam logic [1:0] PAT_RIGHT = 2'b01;
    localparam logic [1:0] PAT_LEFT  = 2'b10;
    localparam logic [1:0] PAT_DOWN  = 2'b00;

    localparam logic [1:0] LVL_1 = 2'b00;
    localparam logic [1:0] LVL_2 = 2'b01;
    localparam logic [1:0] LVL_3 = 2'b10;

    typedef enum logic [1:0] {
        P_RIGHT  = 2'd0,
        P_DOWN_R = 2'd1,
        P_LEFT   = 2'd2,
        P_DOWN_L = 2'd3
    } pat_state_e;

    localparam int unsigned DEF_CNT_W      = 27;
    localparam int unsigned DEF_PERIOD_L1  = 25000000;
    localparam int unsigned DEF_PERIOD_L2  = 12500000;
    localparam int unsigned DEF_PERIOD_L3  = 6250000;
    localparam int unsigned DEF_TRAN_DELAY = 100000000;
    localparam int unsigned DEF_STEPS      = 6;

    function automatic logic [1:0] pat_code(input pat_state_e st);
        logic [1:0] code;
        case (st)
            P_RIGHT: code = PAT_RIGHT;
            P_LEFT:  code = PAT_LEFT;
            default: code = PAT_DOWN;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/si_alien_tick_scheduler_if.sv
// Strobe/level/flag bundle between the alien FSM (master) and the tick scheduler
// (slave). SI_ALIEN_TICK_SPEEDUP_EN adds the active-low speed-up request.
interface si_alien_tick_scheduler_if;
    logic       SI_ALIEN_TICK_ENABLE_COUNTMA_InLow;
    logic       SI_ALIEN_TICK_COUNTUP_InLow;
    logic       SI_ALIEN_TICK_CLEARCOUNT_InLow;
    logic       SI_ALIEN_TICK_ENABLE_COUNTRA_InLow;
    logic [1:0] SI_ALIEN_TICK_LEVEL_In;
    logic       SI_ALIEN_TICK_COUNTMA_OutLow;
    logic [1:0] SI_ALIEN_TICK_COUNT4MA_Out;
    logic       SI_ALIEN_TICK_COUNTRA_OutLow;
`ifdef SI_ALIEN_TICK_SPEEDUP_EN
    logic       SI_ALIEN_TICK_SPEEDUP_InLow;

    modport master (
        output SI_ALIEN_TICK_ENABLE_COUNTMA_InLow, SI_ALIEN_TICK_COUNTUP_InLow,
               SI_ALIEN_TICK_CLEARCOUNT_InLow, SI_ALIEN_TICK_ENABLE_COUNTRA_InLow,
               SI_ALIEN_TICK_LEVEL_In, SI_ALIEN_TICK_SPEEDUP_InLow,
        input  SI_ALIEN_TICK_COUNTMA_OutLow, SI_ALIEN_TICK_COUNT4MA_Out,
               SI_ALIEN_TICK_COUNTRA_OutLow
    );
    modport slave (
        input  SI_ALIEN_TICK_ENABLE_COUNTMA_InLow, SI_ALIEN_TICK_COUNTUP_InLow,
               SI_ALIEN_TICK_CLEARCOUNT_InLow, SI_ALIEN_TICK_ENABLE_COUNTRA_InLow,
               SI_ALIEN_TICK_LEVEL_In, SI_ALIEN_TICK_SPEEDUP_InLow,
        output SI_ALIEN_TICK_COUNTMA_OutLow, SI_ALIEN_TICK_COUNT4MA_Out,
               SI_ALIEN_TICK_COUNTRA_OutLow
    );
`else
    modport master (
        output SI_ALIEN_TICK_ENABLE_COUNTMA_InLow, SI_ALIEN_TICK_COUNTUP_InLow,
               SI_ALIEN_TICK_CLEARCOUNT_InLow, SI_ALIEN_TICK_ENABLE_COUNTRA_InLow,
               SI_ALIEN_TICK_LEVEL_In,
        input  SI_ALIEN_TICK_COUNTMA_OutLow, SI_ALIEN_TICK_COUNT4MA_Out,
               SI_ALIEN_TICK_COUNTRA_OutLow
    );
    modport slave (
        input  SI_ALIEN_TICK_ENABLE_COUNTMA_InLow, SI_ALIEN_TICK_COUNTUP_InLow,
               SI_ALIEN_TICK_CLEARCOUNT_InLow, SI_ALIEN_TICK_ENABLE_COUNTRA_InLow,
               SI_ALIEN_TICK_LEVEL_In,
        output SI_ALIEN_TICK_COUNTMA_OutLow, SI_ALIEN_TICK_COUNT4MA_Out,
               SI_ALIEN_TICK_COUNTRA_OutLow
    );
`endif
endinterface

// File: rtl/si_terminal_counter.sv
// Up-counter with clear, terminal compare and a registered done flag; wraps to
// zero (one-cycle done pulse) or saturates (done held) depending on sat_mode.
module si_terminal_counter #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             sat_mode,
    input  logic [CNT_W-1:0] terminal,
    output logic             at_term,
    output logic             done
);
    logic [CNT_W-1:0] count_r;
    logic             done_r;

    // at_term marks the edge on which the counter reloads or saturates
    assign at_term = enable && !clear && (count_r == terminal);
    assign done    = done_r;

    // Count register and done flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else if (enable) begin
            if (count_r == terminal) begin
                count_r <= sat_mode ? count_r : {CNT_W{1'b0}};
                done_r  <= 1'b1;
            end else begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                done_r  <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end
endmodule

// File: rtl/si_alien_tick_scheduler.sv
// Move tick, row pattern and transition-delay scheduler for the alien FSM.
// Optional SI_ALIEN_TICK_SPEEDUP_EN halves the move period on request.
module si_alien_tick_scheduler
    import si_alien_tick_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned PERIOD_L1  = DEF_PERIOD_L1,
    parameter int unsigned PERIOD_L2  = DEF_PERIOD_L2,
    parameter int unsigned PERIOD_L3  = DEF_PERIOD_L3,
    parameter int unsigned TRAN_DELAY = DEF_TRAN_DELAY,
    parameter int unsigned STEPS      = DEF_STEPS
) (
    input logic                     SI_ALIEN_TICK_CLOCK_50,
    input logic                     SI_ALIEN_TICK_RESET_InLow,
    si_alien_tick_scheduler_if.slave bus
);
    localparam logic [CNT_W-1:0] P1_VAL     = CNT_W'(PERIOD_L1);
    localparam logic [CNT_W-1:0] P2_VAL     = CNT_W'(PERIOD_L2);
    localparam logic [CNT_W-1:0] P3_VAL     = CNT_W'(PERIOD_L3);
    localparam logic [CNT_W-1:0] ONE_VAL    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DELAY_TERM = CNT_W'(TRAN_DELAY - 1);
    localparam logic [3:0]       STEP_LAST  = 4'(STEPS - 1);

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] base_period_s;
    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] cur_term_r;
    logic             move_hit_s;
    logic             move_done_s;
    logic             delay_hit_s;
    logic             delay_done_s;
    pat_state_e       state_r, state_n;
    logic [3:0]       step_r, step_n;
    logic [1:0]       code_r;
`ifdef SI_ALIEN_TICK_SPEEDUP_EN
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
    logic [CNT_W-1:0] half_period_s;
`endif

    assign clk   = SI_ALIEN_TICK_CLOCK_50;
    assign rst_n = SI_ALIEN_TICK_RESET_InLow;

    // Period selection from level code (and optional speed-up request)
    always_comb begin
        case (bus.SI_ALIEN_TICK_LEVEL_In)
            LVL_1:   base_period_s = P1_VAL;
            LVL_2:   base_period_s = P2_VAL;
            LVL_3:   base_period_s = P3_VAL;
            default: base_period_s = P1_VAL;
        endcase
`ifdef SI_ALIEN_TICK_SPEEDUP_EN
        half_period_s = base_period_s >> 1;
        if (bus.SI_ALIEN_TICK_SPEEDUP_InLow) begin
            period_s = base_period_s;
        end else if (half_period_s < MIN_PERIOD) begin
            period_s = MIN_PERIOD;
        end else begin
            period_s = half_period_s;
        end
`else
        period_s = base_period_s;
`endif
    end

    // Terminal count latch: idle (enable high) and every reload, so a level
    // change mid-period only affects the following period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_term_r <= P1_VAL - ONE_VAL;
        end else if (bus.SI_ALIEN_TICK_ENABLE_COUNTMA_InLow || move_hit_s) begin
            cur_term_r <= period_s - ONE_VAL;
        end else begin
            cur_term_r <= cur_term_r;
        end
    end

    si_terminal_counter #(.CNT_W(CNT_W)) u_move_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.SI_ALIEN_TICK_ENABLE_COUNTMA_InLow),
        .enable   (!bus.SI_ALIEN_TICK_ENABLE_COUNTMA_InLow),
        .sat_mode (1'b0),
        .terminal (cur_term_r),
        .at_term  (move_hit_s),
        .done     (move_done_s)
    );

    si_terminal_counter #(.CNT_W(CNT_W)) u_delay_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.SI_ALIEN_TICK_ENABLE_COUNTRA_InLow),
        .enable   (!bus.SI_ALIEN_TICK_ENABLE_COUNTRA_InLow),
        .sat_mode (1'b1),
        .terminal (DELAY_TERM),
        .at_term  (delay_hit_s),
        .done     (delay_done_s)
    );

    // Pattern FSM next-state: clear dominates a simultaneous step request
    always_comb begin
        state_n = state_r;
        step_n  = step_r;
        if (!bus.SI_ALIEN_TICK_CLEARCOUNT_InLow) begin
            state_n = P_RIGHT;
            step_n  = 4'd0;
        end else if (!bus.SI_ALIEN_TICK_COUNTUP_InLow) begin
            case (state_r)
                P_RIGHT, P_LEFT: begin
                    if (step_r == STEP_LAST) begin
                        state_n = (state_r == P_RIGHT) ? P_DOWN_R : P_DOWN_L;
                        step_n  = 4'd0;
                    end else begin
                        step_n = step_r + 4'd1;
                    end
                end
                P_DOWN_R: state_n = P_LEFT;
                P_DOWN_L: state_n = P_RIGHT;
                default: begin
                    state_n = P_RIGHT;
                    step_n  = 4'd0;
                end
            endcase
        end else begin
            state_n = state_r;
            step_n  = step_r;
        end
    end

    // Pattern FSM state, step and registered pattern code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= P_RIGHT;
            step_r  <= 4'd0;
            code_r  <= PAT_RIGHT;
        end else begin
            state_r <= state_n;
            step_r  <= step_n;
            code_r  <= pat_code(state_n);
        end
    end

    assign bus.SI_ALIEN_TICK_COUNTMA_OutLow = ~move_done_s;
    assign bus.SI_ALIEN_TICK_COUNT4MA_Out   = code_r;
    assign bus.SI_ALIEN_TICK_COUNTRA_OutLow = ~delay_done_s;

    logic unused_s;
    assign unused_s = delay_hit_s;
endmodule
